// File: rtl/mio_responder.sv
// mio_responder: memory/IO responder on the far side of the MCPU bus.
// Services CPU_MIO requests from a word RAM, a GPIO register, a switch
// input and a compare timer. Each access completes with a one-cycle
// MIO_ready pulse after a region-dependent number of wait states.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   CPU_MIO, mem_w  - request valid and write/read select
//   Addr_out        - byte address; Data_out - write data
//   Data_in         - read data, held until the next read commit
//   MIO_ready       - completion pulse; bus_err flags illegal accesses
//   INT             - timer compare interrupt (level)
//   sw_in, gpio_out - switch inputs and GPIO output register
module mio_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned WAIT_RAM  = 1,
    parameter int unsigned WAIT_IO   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        INT,
    output logic        bus_err,
    input  logic [15:0] sw_in,
    output logic [31:0] gpio_out
);

    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam int unsigned RAM_BYTES = RAM_WORDS * 4;
    localparam logic [31:0] ADDR_GPIO = 32'hE000_0000;
    localparam logic [31:0] ADDR_SW   = 32'hF000_0000;
    localparam logic [31:0] ADDR_CNT  = 32'hF000_0004;
    localparam logic [31:0] ADDR_CMP  = 32'hF000_0008;
    localparam logic [31:0] ADDR_STAT = 32'hF000_000C;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] data_in_q, data_in_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        int_q, int_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;

    logic [31:0] ram [RAM_WORDS];

    logic [31:0]      cur_addr, cur_wdata;
    logic             cur_we;
    logic             is_ram, is_gpio, is_sw, is_cnt, is_cmp, is_stat, illegal;
    logic [3:0]       load_wait;
    logic [IDX_W-1:0] ram_idx;
    logic             commit;
    logic             ram_we;

    // In IDLE the commit (zero-wait case) must use the live request; later, the latched copy.
    assign cur_addr  = (state_q == S_IDLE) ? Addr_out : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? Data_out : wdata_q;
    assign cur_we    = (state_q == S_IDLE) ? mem_w    : we_q;

    // Address decode; low two address bits are ignored for IO registers.
    assign is_ram    = (cur_addr < 32'(RAM_BYTES));
    assign is_gpio   = (cur_addr[31:2] == ADDR_GPIO[31:2]);
    assign is_sw     = (cur_addr[31:2] == ADDR_SW[31:2]);
    assign is_cnt    = (cur_addr[31:2] == ADDR_CNT[31:2]);
    assign is_cmp    = (cur_addr[31:2] == ADDR_CMP[31:2]);
    assign is_stat   = (cur_addr[31:2] == ADDR_STAT[31:2]);
    assign illegal   = !(is_ram || is_gpio || is_sw || is_cnt || is_cmp || is_stat)
                       || (is_sw && cur_we);
    assign load_wait = is_ram ? 4'(WAIT_RAM) : 4'(WAIT_IO);
    assign ram_idx   = cur_addr[IDX_W+1:2];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, request latch and wait counter.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CPU_MIO) begin
                    addr_d  = Addr_out;
                    wdata_d = Data_out;
                    we_d    = mem_w;
                    wcnt_d  = load_wait;
                    if (load_wait != 4'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: register updates, read mux, timer and interrupt.
    always_comb begin
        data_in_d = data_in_q;
        ready_d   = commit;
        err_d     = commit && illegal;
        gpio_d    = gpio_q;
        count_d   = count_q + 32'd1;
        cmp_d     = cmp_q;
        int_d     = int_q;
        ram_we    = 1'b0;
        if (commit) begin
            if (cur_we) begin
                if (!illegal) begin
                    if (is_gpio) gpio_d = cur_wdata;
                    if (is_cnt)  count_d = cur_wdata;
                    if (is_cmp)  cmp_d = cur_wdata;
                    if (is_stat) int_d = 1'b0;
                    ram_we = is_ram;
                end
            end else if (illegal) begin
                data_in_d = 32'h0;
            end else if (is_ram) begin
                data_in_d = ram[ram_idx];
            end else if (is_gpio) begin
                data_in_d = gpio_q;
            end else if (is_sw) begin
                data_in_d = {16'h0, sw_in};
            end else if (is_cnt) begin
                data_in_d = count_q;
            end else if (is_cmp) begin
                data_in_d = cmp_q;
            end else begin
                data_in_d = {31'h0, int_q};
            end
        end
        // Set after the clear so a same-edge match wins.
        if ((count_q == cmp_q) && (cmp_q != 32'h0)) int_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q    <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            we_q      <= 1'b0;
            data_in_q <= 32'h0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            int_q     <= 1'b0;
            gpio_q    <= 32'h0;
            count_q   <= 32'h0;
            cmp_q     <= 32'h0;
        end else begin
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            data_in_q <= data_in_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            int_q     <= int_d;
            gpio_q    <= gpio_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
        end
    end

    // Word RAM, not reset; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram[ram_idx] <= cur_wdata;
        end
    end

    assign Data_in   = data_in_q;
    assign MIO_ready = ready_q;
    assign bus_err   = err_q;
    assign INT       = int_q;
    assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_mio_responder.sv
// Testbench for mio_responder: table of bus accesses checked through a
// scoreboard queue, plus hand sequences for timer, interrupt, wrap and abort.
module tb_mio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        INT;
    logic        bus_err;
    logic [15:0] sw_in;
    logic [31:0] gpio_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_gpio;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[17];

    mio_responder dut (
        .clk      (clk),
        .reset    (reset),
        .CPU_MIO  (CPU_MIO),
        .mem_w    (mem_w),
        .Addr_out (Addr_out),
        .Data_out (Data_out),
        .Data_in  (Data_in),
        .MIO_ready(MIO_ready),
        .INT      (INT),
        .bus_err  (bus_err),
        .sw_in    (sw_in),
        .gpio_out (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus access: expectation pushed when driven, popped at MIO_ready.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat);
        exp_t e;
        int   lat;
        bit   seen;
        sb.push_back('{exp_data, exp_err, exp_lat});
        @(negedge clk);
        CPU_MIO  = 1'b1;
        mem_w    = we;
        Addr_out = addr;
        Data_out = wdata;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (MIO_ready) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
        end
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no MIO_ready within 20 cycles", tag);
        end else begin
            chk({tag, " latency"}, 32'(lat), 32'(e.lat));
            chk({tag, " data"}, Data_in, e.data);
            chk({tag, " bus_err"}, 32'(bus_err), 32'(e.err));
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        vecs[0]  = '{1'b1, 32'h0000_03E0, 32'h0000_0001, 16'h0,    32'h0,         1'b0, 2, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_03E0, 32'h0,         16'h0,    32'h1,         1'b0, 2, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_03E0, 32'h0000_0055, 16'h0,    32'h1,         1'b0, 2, 32'h0};
        vecs[3]  = '{1'b1, 32'hE000_0000, 32'hA5A5_A5A5, 16'h0,    32'h1,         1'b0, 3, 32'hA5A5_A5A5};
        vecs[4]  = '{1'b0, 32'hE000_0000, 32'h0,         16'h0,    32'hA5A5_A5A5, 1'b0, 3, 32'hA5A5_A5A5};
        vecs[5]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h1234, 32'h0000_1234, 1'b0, 3, 32'hA5A5_A5A5};
        vecs[6]  = '{1'b1, 32'hF000_0000, 32'h0000_FFFF, 16'h1234, 32'h0000_1234, 1'b1, 3, 32'hA5A5_A5A5};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         16'h1234, 32'h0,         1'b1, 3, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b0, 32'h0000_03E3, 32'h0,         16'h0,    32'h0000_0055, 1'b0, 2, 32'hA5A5_A5A5};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 16'h0,    32'h0000_0055, 1'b0, 2, 32'hA5A5_A5A5};
        vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'h0,    32'h0000_0055, 1'b0, 2, 32'hA5A5_A5A5};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         16'h0,    32'hCAFE_F00D, 1'b0, 2, 32'hA5A5_A5A5};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         16'h0,    32'h1234_5678, 1'b0, 2, 32'hA5A5_A5A5};
        vecs[13] = '{1'b0, 32'h0000_1000, 32'h0,         16'h0,    32'h0,         1'b1, 3, 32'hA5A5_A5A5};
        vecs[14] = '{1'b1, 32'hE000_0004, 32'h0000_0001, 16'h0,    32'h0,         1'b1, 3, 32'hA5A5_A5A5};
        vecs[15] = '{1'b0, 32'hF000_0010, 32'h0,         16'h0,    32'h0,         1'b1, 3, 32'hA5A5_A5A5};
        vecs[16] = '{1'b1, 32'hE000_0000, 32'h0000_003C, 16'h0,    32'h0,         1'b0, 3, 32'h0000_003C};

        reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0;
        Addr_out = 32'h0; Data_out = 32'h0; sw_in = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset Data_in", Data_in, 32'h0);
        chk("reset MIO_ready", 32'(MIO_ready), 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
        chk("reset INT", 32'(INT), 32'h0);
        chk("reset gpio_out", gpio_out, 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (MIO_ready) seen = 1'b1;
        end
        chk("idle no ready", 32'(seen), 32'h0);

        for (int i = 0; i < 17; i++) begin
            sw_in = vecs[i].sw;
            access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
            chk($sformatf("vec%0d gpio", i), gpio_out, vecs[i].exp_gpio);
            @(negedge clk);
            chk($sformatf("vec%0d single pulse", i), 32'(MIO_ready), 32'h0);
            chk($sformatf("vec%0d err drop", i), 32'(bus_err), 32'h0);
        end

        // Timer compare: INT rises 21 cycles after count is written to 0.
        access("cmp20", 1'b1, 32'hF000_0008, 32'd20, 32'h0, 1'b0, 3);
        access("cnt0", 1'b1, 32'hF000_0004, 32'd0, 32'h0, 1'b0, 3);
        chk("int before match", 32'(INT), 32'h0);
        seen = 1'b0; n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (INT) begin
                n = k;
                seen = 1'b1;
                break;
            end
        end
        chk("int rise seen", 32'(seen), 32'h1);
        chk("int rise cycle", 32'(n), 32'd21);
        access("stat read", 1'b0, 32'hF000_000C, 32'h0, 32'h1, 1'b0, 3);
        access("stat clr", 1'b1, 32'hF000_000C, 32'h0, 32'h1, 1'b0, 3);
        chk("int cleared", 32'(INT), 32'h0);

        // Clear on the same edge as a match: count 0 -> commit edge sees count 3.
        access("cmp3", 1'b1, 32'hF000_0008, 32'd3, 32'h1, 1'b0, 3);
        access("cnt0b", 1'b1, 32'hF000_0004, 32'd0, 32'h1, 1'b0, 3);
        access("stat clr match", 1'b1, 32'hF000_000C, 32'h0, 32'h1, 1'b0, 3);
        chk("int set wins", 32'(INT), 32'h1);

        // Timer wrap: FFFFFFFE in ready cycle, read commits three edges later.
        sw_in = 16'hBEEF;
        access("sw beef", 1'b0, 32'hF000_0000, 32'h0, 32'h0000_BEEF, 1'b0, 3);
        access("cnt wrap wr", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0000_BEEF, 1'b0, 3);
        access("cnt wrap rd", 1'b0, 32'hF000_0004, 32'h0, 32'h0000_0001, 1'b0, 3);

        // Abort: reset during WAIT of a RAM write.
        access("preload", 1'b1, 32'h0000_0010, 32'h0, 32'h1, 1'b0, 2);
        @(negedge clk);
        CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h0000_0010; Data_out = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (MIO_ready) seen = 1'b1;
        end
        chk("abort no ready", 32'(seen), 32'h0);
        chk("abort Data_in", Data_in, 32'h0);
        chk("abort gpio", gpio_out, 32'h0);
        reset = 1'b0;
        access("abort read", 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
